// File: rtl/mux_arbiter.sv
// Two-requester arbitrated multiplexer.
// Requester 0 and requester 1 compete for one data path. A granted requester
// keeps the mux for up to MAX_BURST consecutive cycles while the other one
// waits; ties out of IDLE go to whichever side did not own the mux last.
// The selected data and a valid flag are registered one cycle after the grant.
module mux_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_0,
    input  logic             req_1,
    input  logic [WIDTH-1:0] din_0,
    input  logic [WIDTH-1:0] din_1,
    output logic             gnt_0,
    output logic             gnt_1,
    output logic             sel,
    output logic [WIDTH-1:0] mux_out,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Burst limit in the width of the counter; legal values are 1..15.
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t             state_q, state_d;
    logic               last_q, last_d;     // 0/1: requester that owned the mux most recently
    logic [3:0]         cnt_q, cnt_d;       // consecutive cycles of the current ownership
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   mux_q;
    logic               valid_q;

    // Next-state arbitration: ownership, tie-break and burst limiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_0 && req_1) begin
                    // Tie: hand the mux to the side that did not have it last.
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req_0) begin
                    state_d = OWN0;
                end else if (req_1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req_0) begin
                    state_d = req_1 ? OWN1 : IDLE;
                end else if ((cnt_q == MAX_CNT) && req_1) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req_1) begin
                    state_d = req_0 ? OWN0 : IDLE;
                end else if ((cnt_q == MAX_CNT) && req_0) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst counter, last-owner tracking and select, all keyed on the next state.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        sel_d  = sel_q;
        if (state_d == IDLE) begin
            cnt_d = 4'd0;
        end else if (state_d != state_q) begin
            // Fresh ownership (from IDLE or a direct hand-over).
            cnt_d  = 4'd1;
            last_d = (state_d == OWN1);
        end else if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (state_d == OWN1) begin
            sel_d = 1'b1;
        end else if (state_d == OWN0) begin
            sel_d = 1'b0;
        end
    end

    // State, counter, owner and select registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;   // requester 0 wins the first tie after reset
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    // Data path: register the currently selected input and whether its owner is still requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            mux_q   <= sel_q ? din_1 : din_0;
            valid_q <= ((state_q == OWN0) && req_0) || ((state_q == OWN1) && req_1);
        end
    end

    assign gnt_0     = (state_q == OWN0);
    assign gnt_1     = (state_q == OWN1);
    assign sel       = sel_q;
    assign mux_out   = mux_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios with constant
// expectations, then a long random run against a behavioural reference model
// whose expected data/valid results flow through a scoreboard queue.
module tb_mux_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_0, req_1;
    logic [W-1:0] din_0, din_1;
    logic         gnt_0, gnt_1, sel;
    logic [W-1:0] mux_out;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    mux_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_0     (req_0),
        .req_1     (req_1),
        .din_0     (din_0),
        .din_1     (din_1),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .sel       (sel),
        .mux_out   (mux_out),
        .out_valid (out_valid)
    );

    initial forever #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_0 = 1'b0;
        req_1 = 1'b0;
        din_0 = '0;
        din_1 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Dirty the outputs first so the reset values are meaningful.
        rst = 1'b0; req_0 = 1'b0; req_1 = 1'b1; din_0 = 8'h00; din_1 = 8'hA5;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if (gnt_0 !== 1'b0)     begin errors++; $display("FAIL reset_gnt_0 got %b want 0", gnt_0); end
        checks++; if (gnt_1 !== 1'b0)     begin errors++; $display("FAIL reset_gnt_1 got %b want 0", gnt_1); end
        checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL reset_sel got %b want 0", sel); end
        checks++; if (mux_out !== 8'h00)  begin errors++; $display("FAIL reset_mux_out got %h want 00", mux_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", dut.cnt_q); end
        checks++; if (dut.last_q !== 1'b1) begin errors++; $display("FAIL reset_last_owner got %b want 1", dut.last_q); end
        rst = 1'b0; req_1 = 1'b0;
        $display("test_reset done");
    endtask

    // Both requesting continuously: 4 cycles each, alternating.
    task automatic test_burst();
        do_reset();
        req_0 = 1'b1; req_1 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            logic e0;
            tick();
            e0 = (c <= 4) || (c == 9);
            checks++; if (gnt_0 !== e0)  begin errors++; $display("FAIL burst_gnt_0 cycle %0d got %b want %b", c, gnt_0, e0); end
            checks++; if (gnt_1 !== !e0) begin errors++; $display("FAIL burst_gnt_1 cycle %0d got %b want %b", c, gnt_1, !e0); end
        end
        $display("test_burst done");
    endtask

    // Single requester 1: grant and select after one edge, data after two.
    task automatic test_single();
        do_reset();
        req_1 = 1'b1; din_1 = 8'h01; din_0 = 8'h00;
        tick();
        checks++; if (gnt_1 !== 1'b1)     begin errors++; $display("FAIL single_gnt_1 got %b want 1", gnt_1); end
        checks++; if (gnt_0 !== 1'b0)     begin errors++; $display("FAIL single_gnt_0 got %b want 0", gnt_0); end
        checks++; if (sel !== 1'b1)       begin errors++; $display("FAIL single_sel got %b want 1", sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        tick();
        checks++; if (mux_out !== 8'h01)  begin errors++; $display("FAIL single_mux_out got %h want 01", mux_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        req_1 = 1'b0;
        $display("test_single done");
    endtask

    // Owner 0 drops mid-burst while 1 waits: direct hand-over, invalid data cycle.
    task automatic test_drop();
        do_reset();
        req_0 = 1'b1; req_1 = 1'b1;
        tick(); tick();
        checks++; if (dut.cnt_q !== 4'd2) begin errors++; $display("FAIL drop_cnt_before got %0d want 2", dut.cnt_q); end
        checks++; if (gnt_0 !== 1'b1)     begin errors++; $display("FAIL drop_gnt_0_before got %b want 1", gnt_0); end
        req_0 = 1'b0;
        tick();
        checks++; if (gnt_1 !== 1'b1)     begin errors++; $display("FAIL drop_gnt_1 got %b want 1", gnt_1); end
        checks++; if (gnt_0 !== 1'b0)     begin errors++; $display("FAIL drop_gnt_0 got %b want 0", gnt_0); end
        checks++; if (dut.cnt_q !== 4'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", dut.cnt_q); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drop_valid_after got %b want 1", out_valid); end
        req_1 = 1'b0;
        $display("test_drop done");
    endtask

    // Lone requester held 10 cycles: never released, counter saturates.
    task automatic test_hold();
        logic [W-1:0] prev;
        do_reset();
        req_0 = 1'b1;
        prev  = '0;
        for (int c = 1; c <= 10; c++) begin
            din_0 = W'($urandom);
            din_1 = ~din_0;
            prev  = din_0;
            tick();
            checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL hold_gnt_0 cycle %0d got %b want 1", c, gnt_0); end
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cycle %0d got %b want 1", c, out_valid); end
                checks++; if (mux_out !== prev)   begin errors++; $display("FAIL hold_mux_out cycle %0d got %h want %h", c, mux_out, prev); end
            end
        end
        checks++; if (dut.cnt_q !== 4'd4) begin errors++; $display("FAIL hold_cnt_sat got %0d want 4", dut.cnt_q); end
        req_0 = 1'b0;
        $display("test_hold done");
    endtask

    // Reset in the middle of an OWN1 burst, then restart with a tie.
    task automatic test_mid_reset();
        do_reset();
        req_1 = 1'b1; din_1 = 8'h3C;
        tick(); tick(); tick();
        checks++; if (dut.cnt_q !== 4'd3) begin errors++; $display("FAIL midrst_cnt got %0d want 3", dut.cnt_q); end
        rst = 1'b1;
        tick();
        checks++; if (gnt_1 !== 1'b0)      begin errors++; $display("FAIL midrst_gnt_1 got %b want 0", gnt_1); end
        checks++; if (sel !== 1'b0)        begin errors++; $display("FAIL midrst_sel got %b want 0", sel); end
        checks++; if (mux_out !== 8'h00)   begin errors++; $display("FAIL midrst_mux_out got %h want 00", mux_out); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (dut.last_q !== 1'b1) begin errors++; $display("FAIL midrst_last got %b want 1", dut.last_q); end
        rst = 1'b0; req_0 = 1'b1; req_1 = 1'b1;
        tick();
        checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL midrst_tie_gnt_0 got %b want 1", gnt_0); end
        checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL midrst_tie_gnt_1 got %b want 0", gnt_1); end
        req_0 = 1'b0; req_1 = 1'b0;
        $display("test_mid_reset done");
    endtask

    // Random traffic against a reference model; data/valid go through a scoreboard queue.
    task automatic test_random();
        logic [W:0] sb[$];
        logic [W:0] exp_entry;
        int  m_state;   // 0 idle, 1 owner 0, 2 owner 1
        int  m_cnt;
        bit  m_last;
        bit  m_sel;
        int  n_state;
        int  wait0, wait1;
        do_reset();
        m_state = 0; m_cnt = 0; m_last = 1'b1; m_sel = 1'b0;
        wait0 = 0; wait1 = 0;
        for (int c = 0; c < 3000; c++) begin
            req_0 = ($urandom_range(0, 3) != 0);
            req_1 = ($urandom_range(0, 3) != 0);
            din_0 = W'($urandom);
            din_1 = W'($urandom);
            // Waiting time of a continuously requesting side, from visible grants.
            wait0 = (req_0 && !gnt_0) ? wait0 + 1 : 0;
            wait1 = (req_1 && !gnt_1) ? wait1 + 1 : 0;
            checks++; if (wait0 > MB + 1) begin errors++; $display("FAIL rand_wait0 cycle %0d got %0d want <= %0d", c, wait0, MB + 1); end
            checks++; if (wait1 > MB + 1) begin errors++; $display("FAIL rand_wait1 cycle %0d got %0d want <= %0d", c, wait1, MB + 1); end
            // Expected registered data for this cycle.
            sb.push_back({(m_sel ? din_1 : din_0),
                          ((m_state == 1) && req_0) || ((m_state == 2) && req_1)});
            // Reference arbitration step.
            if (m_state == 0) begin
                if (req_0 && req_1) n_state = (m_last == 1'b0) ? 2 : 1;
                else if (req_0)     n_state = 1;
                else if (req_1)     n_state = 2;
                else                n_state = 0;
            end else begin
                bit mine, other;
                mine  = (m_state == 1) ? req_0 : req_1;
                other = (m_state == 1) ? req_1 : req_0;
                if (!mine)                      n_state = other ? 3 - m_state : 0;
                else if (m_cnt == MB && other)  n_state = 3 - m_state;
                else                            n_state = m_state;
            end
            if (n_state == 0)              m_cnt = 0;
            else if (n_state != m_state) begin m_cnt = 1; m_last = (n_state == 2); end
            else if (m_cnt < MB)           m_cnt = m_cnt + 1;
            if (n_state == 1) m_sel = 1'b0;
            if (n_state == 2) m_sel = 1'b1;
            m_state = n_state;
            tick();
            exp_entry = sb.pop_front();
            checks++; if (mux_out !== exp_entry[W:1]) begin errors++; $display("FAIL rand_mux_out cycle %0d got %h want %h", c, mux_out, exp_entry[W:1]); end
            checks++; if (out_valid !== exp_entry[0]) begin errors++; $display("FAIL rand_valid cycle %0d got %b want %b", c, out_valid, exp_entry[0]); end
            checks++; if (gnt_0 !== (m_state == 1))   begin errors++; $display("FAIL rand_gnt_0 cycle %0d got %b want %b", c, gnt_0, (m_state == 1)); end
            checks++; if (gnt_1 !== (m_state == 2))   begin errors++; $display("FAIL rand_gnt_1 cycle %0d got %b want %b", c, gnt_1, (m_state == 2)); end
            checks++; if (sel !== m_sel)              begin errors++; $display("FAIL rand_sel cycle %0d got %b want %b", c, sel, m_sel); end
            checks++; if (gnt_0 && gnt_1)             begin errors++; $display("FAIL rand_exclusive cycle %0d got both grants want at most one", c); end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0; din_0 = '0; din_1 = '0;
        tick();
        test_reset();
        test_burst();
        test_single();
        test_drop();
        test_hold();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
